demux_1x2_stream_ctrl: RTL and testbench
========================================

// Module: demux_1x2_stream_ctrl
//
// PURPOSE
//  Packet-aware controller that sequences a 1x2 demultiplexer on a valid/ready stream.
//  Latches the destination on the first beat of each packet and holds the select for
//  the whole packet. Registers each beat in a one-entry output stage and forwards it
//  only to the selected channel. Sits between a single producer and two consumers.
//  Also keeps per-channel packet counts for the benchmarking harness.
//
// PARAMETERS
//  DATA_W  8   payload width of every beat
//  CNT_W   16  width of each per-channel packet counter (wraps)
//
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  enable      in   1       1 = new packets may start; 0 = finish current packet, then hold
//  in_valid    in   1       input beat valid
//  in_ready    out  1       input beat accepted when in_valid & in_ready
//  in_data     in   DATA_W  input payload
//  in_last     in   1       final beat of packet
//  in_dest     in   1       destination channel; sampled only on first beat of packet
//  out0_valid  out  1       channel-0 beat valid
//  out0_ready  in   1       channel-0 consumer ready
//  out0_data   out  DATA_W  channel-0 payload; 0 when out0_valid=0
//  out0_last   out  1       channel-0 last flag; 0 when out0_valid=0
//  out1_*      ...          same four signals for channel 1
//  sel         out  1       currently latched destination
//  busy        out  1       1 in state PKT or while the output stage holds a beat
//  pkt_cnt0    out  CNT_W   packets completed on channel 0 (last beat handed off)
//  pkt_cnt1    out  CNT_W   packets completed on channel 1
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; stage empty; sel=0; counters=0.
//    All out*_valid, data and last are 0. in_ready=0 while rst_n=0.
//    Any in-flight beat or packet is discarded; no partial-packet recovery.
//  - FSM IDLE:
//    - in_ready = enable & stage_can_load.
//    - An accepted beat latches sel<=in_dest.
//    - If in_last=0, go to PKT; if in_last=1 (single-beat packet), stay IDLE.
//  - FSM PKT:
//    - in_ready = stage_can_load; enable is ignored and in_dest is ignored.
//    - The accepted beat with in_last=1 returns the FSM to IDLE.
//  - Output stage (1 entry): stage_can_load = ~stage_full | (selected outN_ready).
//    - A beat accepted at edge t appears at outN_valid after edge t; latency is 1 cycle.
//    - Simultaneous hand-off and load in the same cycle gives full throughput, 1 beat/clk.
//    - Stage channel is the value of sel in force when the beat loads.
//  - Unselected channel: valid/data/last are all 0.
//    - Only the selected channel's ready matters; the other ready is don't-care.
//  - Back-pressure: valid, data and last hold stable while outN_valid & ~outN_ready.
//  - Counters: pkt_cntN += 1 on outN_valid & outN_ready & outN_last. Wrap at 2^CNT_W-1 -> 0.
//  - Channel switch between packets: a new packet to the other channel may load while the
//    stage holds the previous packet's last beat only if that beat hands off this cycle.
//    This means no reordering and no beat is visible on both channels.
//  - enable falling mid-packet: the packet completes; the next first beat is refused.
//  - busy = (state==PKT) | stage_full.
//
// STRUCTURE
//  - Shared package demux_pkg: localparam ST_IDLE=1'b0, ST_PKT=1'b1; default widths.
//  - Sub-module demux_1x2 (existing): instantiate twice.
//    - Steer stage valid by sel_q to produce out0_valid/out1_valid.
//    - Steer the {data,last} bundle through the same demux so unselected outputs are 0.
//  - Everything else is in this module: FSM, stage register, counters.
//
// TESTING
//  1. Reset then idle: rst_n=0 for 3 clk -> all outputs 0, pkt_cnt0=pkt_cnt1=0.
//     After release with in_valid=0 -> busy=0.
//  2. 3-beat packet (dest=1, data A1,A2,A3; in_dest flips to 0 on beat 2), ready tied 1
//     -> out1 shows A1..A3 on consecutive cycles, 1 clk after input.
//     out0_valid stays 0; pkt_cnt1=1.
//  3. Back-pressure: dest=0 packet 0x11,0x22; out0_ready=0 for 4 clk after beat 1
//     -> out0_data holds 0x11, in_ready=0.
//     On ready: 0x22 follows next cycle; pkt_cnt0=1.
//  4. Back-to-back channel switch: 1-beat pkt dest=0 (0x55) then 1-beat pkt dest=1 (0xAA).
//     -> 0x55 on out0 at cycle n, 0xAA on out1 at n+1; never both valid in one cycle.
//  5. enable drop: enable=0 after beat 1 of a 2-beat packet -> beat 2 accepted and delivered.
//     The next packet's first beat sees in_ready=0 until enable=1.
//  6. Async reset mid-packet (stage full, state PKT) -> outputs 0 immediately, before clock.
//     After release, a new packet routes correctly and counters restart at 0.

Source files
------------

// File: rtl/demux_1x2_stream_ctrl_pkg.sv
// Shared definitions for the packet-aware 1x2 stream demultiplexer.
// Holds the FSM state encoding and the default widths.
package demux_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1x2_stream_ctrl_if.sv
// One valid/ready beat channel with packet framing and a destination bit.
// The producer side uses master, the consumer side uses slave.
interface demux_1x2_stream_ctrl_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              dest;

  modport master (output valid, data, last, dest, input ready);
  modport slave  (input valid, data, last, dest, output ready);

endinterface

// File: rtl/demux_1x2_stream_ctrl_demux.sv
// Plain 1-to-2 steering element: the selected output follows d,
// the other output is forced to zero.
module demux_1x2
  import demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] d,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1
);

  assign y0 = sel ? '0 : d;
  assign y1 = sel ? d  : '0;

endmodule

// File: rtl/demux_1x2_stream_ctrl.sv
// Packet-aware controller: latches the destination on each first beat, stages one
// beat and forwards it only to the selected channel, counting completed packets.
module demux_1x2_stream_ctrl
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  demux_1x2_stream_ctrl_if.slave  in_bus,
  demux_1x2_stream_ctrl_if.master out0_bus,
  demux_1x2_stream_ctrl_if.master out1_bus,
  output logic                    sel,
  output logic                    busy,
  output logic [CNT_W-1:0]        pkt_cnt0,
  output logic [CNT_W-1:0]        pkt_cnt1
);

  state_t            state_reg;
  logic              sel_reg;
  logic              stage_full_reg;
  logic              stage_last_reg;
  logic [DATA_W-1:0] stage_data_reg;

  logic              sel_ready;
  logic              stage_can_load;
  logic              handoff;
  logic              in_ready;
  logic              accept;
  logic [DATA_W:0]   stage_bundle;
  logic [DATA_W:0]   bundle0;
  logic [DATA_W:0]   bundle1;
  logic [1:0]        ch_ready;

  assign ch_ready       = {out1_bus.ready, out0_bus.ready};
  assign sel_ready      = ch_ready[sel_reg];
  assign stage_can_load = ~stage_full_reg | sel_ready;
  assign handoff        = stage_full_reg & sel_ready;

  // Inside a packet enable is ignored so the packet always completes.
  assign in_ready = rst_n & stage_can_load & ((state_reg == ST_PKT) | enable);
  assign accept   = in_bus.valid & in_ready;

  assign in_bus.ready = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= 1'b0;
      stage_full_reg <= 1'b0;
      stage_last_reg <= 1'b0;
      stage_data_reg <= '0;
    end else begin
      if (accept) begin
        stage_full_reg <= 1'b1;
        stage_data_reg <= in_bus.data;
        stage_last_reg <= in_bus.last;
        if (state_reg == ST_IDLE) begin
          sel_reg <= in_bus.dest;
        end
        state_reg <= in_bus.last ? ST_IDLE : ST_PKT;
      end else if (handoff) begin
        stage_full_reg <= 1'b0;
      end
    end
  end

  // sel only changes when the stage is empty or draining, so sel_reg is the stage channel.
  assign stage_bundle = stage_full_reg ? {stage_data_reg, stage_last_reg} : '0;

  demux_1x2 #(.W(1)) u_valid_demux (
    .sel (sel_reg),
    .d   (stage_full_reg),
    .y0  (out0_bus.valid),
    .y1  (out1_bus.valid)
  );

  demux_1x2 #(.W(DATA_W + 1)) u_bundle_demux (
    .sel (sel_reg),
    .d   (stage_bundle),
    .y0  (bundle0),
    .y1  (bundle1)
  );

  assign out0_bus.data = bundle0[DATA_W:1];
  assign out0_bus.last = bundle0[0];
  assign out0_bus.dest = 1'b0;
  assign out1_bus.data = bundle1[DATA_W:1];
  assign out1_bus.last = bundle1[0];
  assign out1_bus.dest = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (handoff && stage_last_reg && (sel_reg == 1'(gi))) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign pkt_cnt0 = g_cnt[0].cnt_reg;
  assign pkt_cnt1 = g_cnt[1].cnt_reg;
  assign sel      = sel_reg;
  assign busy     = (state_reg == ST_PKT) | stage_full_reg;

endmodule

// File: tb/tb_demux_1x2_stream_ctrl.sv
// Bench for demux_1x2_stream_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the stream.
module tb_demux_1x2_stream_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          sel;
  logic          busy;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;

  demux_1x2_stream_ctrl_if #(.DATA_W(DW)) in_if ();
  demux_1x2_stream_ctrl_if #(.DATA_W(DW)) out0_if ();
  demux_1x2_stream_ctrl_if #(.DATA_W(DW)) out1_if ();

  demux_1x2_stream_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_bus   (in_if),
    .out0_bus (out0_if),
    .out1_bus (out1_if),
    .sel      (sel),
    .busy     (busy),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a packet-open flag, the current destination, a pending-beat FIFO of
  // depth at most one, and a completed-packet tally per channel.
  bit         m_pkt;
  bit         m_sel;
  logic [8:0] m_q[$];
  int         m_cnt[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pkt = 0;
    m_sel = 0;
    m_q.delete();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  function automatic bit model_in_ready();
    bit room;
    bit dst_ready;
    dst_ready = m_sel ? out1_if.ready : out0_if.ready;
    room = (m_q.size() == 0) || dst_ready;
    return rst_n && room && (m_pkt || enable);
  endfunction

  task automatic compare_all();
    bit   has;
    logic [8:0] head;
    has  = m_q.size() != 0;
    head = has ? m_q[0] : 9'h0;
    chk("out0_valid", out0_if.valid, (has && !m_sel) ? 1 : 0);
    chk("out1_valid", out1_if.valid, (has && m_sel) ? 1 : 0);
    chk("out0_data", out0_if.data, (has && !m_sel) ? head[8:1] : 0);
    chk("out1_data", out1_if.data, (has && m_sel) ? head[8:1] : 0);
    chk("out0_last", out0_if.last, (has && !m_sel) ? head[0] : 0);
    chk("out1_last", out1_if.last, (has && m_sel) ? head[0] : 0);
    chk("in_ready", in_if.ready, model_in_ready());
    chk("busy", busy, (m_pkt || has) ? 1 : 0);
    chk("pkt_cnt0", pkt_cnt0, m_cnt[0] % (1 << CW));
    chk("pkt_cnt1", pkt_cnt1, m_cnt[1] % (1 << CW));
    if (has) chk("sel", sel, m_sel);
    chk("both_valid", out0_if.valid & out1_if.valid, 0);
  endtask

  task automatic model_step();
    bit acc;
    bit dst_ready;
    if (!rst_n) return;
    acc       = in_if.valid && model_in_ready();
    dst_ready = m_sel ? out1_if.ready : out0_if.ready;
    if (m_q.size() != 0 && dst_ready) begin
      $display("beat ch=%0d data=%02h last=%0d", m_sel, m_q[0][8:1], m_q[0][0]);
      if (m_q[0][0]) m_cnt[m_sel]++;
      void'(m_q.pop_front());
    end
    if (acc) begin
      if (!m_pkt) m_sel = in_if.dest;
      m_q.push_back({in_if.data, in_if.last});
      m_pkt = !in_if.last;
    end
  endtask

  // Inputs are set just after a falling edge; this checks, advances the model
  // across the next rising edge and returns on the following falling edge.
  task automatic cycle();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit dst);
    in_if.valid = v;
    in_if.data  = d;
    in_if.last  = l;
    in_if.dest  = dst;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    drive(0, 8'h00, 0, 0);
    out0_if.ready = 1'b0;
    out1_if.ready = 1'b0;
    model_reset();
    @(negedge clk);

    // 1. reset, then idle
    repeat (3) cycle();
    chk("t1_cnt0", pkt_cnt0, 0);
    chk("t1_cnt1", pkt_cnt1, 0);
    rst_n = 1'b1;
    cycle();
    chk("t1_busy", busy, 0);

    // 2. three-beat packet to channel 1, in_dest flips mid-packet
    enable = 1'b1;
    out0_if.ready = 1'b1;
    out1_if.ready = 1'b1;
    drive(1, 8'hA1, 0, 1); cycle();
    chk("t2_b1_data", out1_if.data, 8'hA1);
    drive(1, 8'hA2, 0, 0); cycle();
    chk("t2_b2_data", out1_if.data, 8'hA2);
    chk("t2_b2_v0", out0_if.valid, 0);
    drive(1, 8'hA3, 1, 0); cycle();
    chk("t2_b3_data", out1_if.data, 8'hA3);
    chk("t2_b3_last", out1_if.last, 1);
    drive(0, 8'h00, 0, 0); cycle();
    chk("t2_cnt1", pkt_cnt1, 1);

    // 3. back-pressure on channel 0
    out0_if.ready = 1'b0;
    drive(1, 8'h11, 0, 0); cycle();
    drive(1, 8'h22, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_hold_data", out0_if.data, 8'h11);
      chk("t3_in_ready", in_if.ready, 0);
      cycle();
    end
    out0_if.ready = 1'b1;
    cycle();
    chk("t3_next_data", out0_if.data, 8'h22);
    drive(0, 8'h00, 0, 0); cycle();
    chk("t3_cnt0", pkt_cnt0, 1);

    // 4. back-to-back single-beat packets switching channel
    drive(1, 8'h55, 1, 0); cycle();
    chk("t4_v0", out0_if.valid, 1);
    chk("t4_d0", out0_if.data, 8'h55);
    drive(1, 8'hAA, 1, 1); cycle();
    chk("t4_v1", out1_if.valid, 1);
    chk("t4_d1", out1_if.data, 8'hAA);
    chk("t4_v0_off", out0_if.valid, 0);
    drive(0, 8'h00, 0, 0); cycle();

    // 5. enable drops mid-packet
    drive(1, 8'h31, 0, 1); cycle();
    enable = 1'b0;
    drive(1, 8'h32, 1, 0);
    #1 chk("t5_b2_ready", in_if.ready, 1);
    cycle();
    chk("t5_b2_data", out1_if.data, 8'h32);
    drive(1, 8'h41, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_refused", in_if.ready, 0);
      cycle();
    end
    enable = 1'b1;
    cycle();
    chk("t5_new_data", out0_if.data, 8'h41);
    drive(0, 8'h00, 0, 0); cycle();

    // 6. asynchronous reset mid-packet
    out1_if.ready = 1'b0;
    drive(1, 8'h61, 0, 1); cycle();
    drive(0, 8'h00, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_v1", out1_if.valid, 0);
    chk("t6_d1", out1_if.data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt1", pkt_cnt1, 0);
    chk("t6_ready", in_if.ready, 0);
    cycle();
    rst_n = 1'b1;
    out0_if.ready = 1'b1;
    out1_if.ready = 1'b1;
    cycle();
    drive(1, 8'h77, 1, 0); cycle();
    chk("t6_new_d0", out0_if.data, 8'h77);
    drive(0, 8'h00, 0, 0); cycle();
    chk("t6_cnt0", pkt_cnt0, 1);

    // Random traffic; the narrow counters wrap several times here.
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      out0_if.ready = ($urandom_range(0, 3) != 0);
      out1_if.ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
            1'($urandom));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
